arm_pick_place_seq: RTL and testbench

Pick-and-place sequencer that sits directly upstream of the arm model. It accepts one pick coordinate and one drop coordinate with a start pulse. It then drives the arm model's x, y, en1, en2, set_xita1, set_xita2 and catch inputs through a fixed timed sequence: home, move to pick, grip, lift, move to drop, release, return. All coordinates and angles are Q16.16 signed, 32-bit, in the same units as the arm model (cm, angle code).

---
 rtl/arm_pick_place_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_arm_pick_place_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_pick_place_seq.sv
// arm_pick_place_seq
//   Pick-and-place sequencer driving the arm model through a fixed timed
//   sequence: home, move to pick, grip, lift, move to drop, release, return.
//   Coordinates and angles are Q16.16 signed, 32-bit.
//
// Ports
//   clk, rst           : system clock, asynchronous active-high reset
//   start              : one-cycle request, honoured only in IDLE
//   abort              : level, forces a safe return without a done pulse
//   pick_x/y, drop_x/y : target coordinates, latched on an accepted start
//   x, y               : arm model target coordinate
//   en1, en2           : arm model IK mode / forced-angle mode (never both 1)
//   set_xita1/2        : forced joint angles, constant home angles
//   catch              : gripper closed
//   busy               : high in every state except IDLE
//   done               : one-cycle pulse on normal completion
//   err                : sticky reject/abort flag, cleared by an accepted start
module arm_pick_place_seq #(
   parameter logic [31:0] T_MOVE     = 32'd5_000_000,
   parameter logic [31:0] T_GRIP     = 32'd25_000_000,
   parameter logic [31:0] HOME_XITA1 = 32'h005A_0000,
   parameter logic [31:0] HOME_XITA2 = 32'h005A_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] pick_x,
   input  logic [31:0] pick_y,
   input  logic [31:0] drop_x,
   input  logic [31:0] drop_y,
   output logic [31:0] x,
   output logic [31:0] y,
   output logic        en1,
   output logic        en2,
   output logic [31:0] set_xita1,
   output logic [31:0] set_xita2,
   output logic        catch,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned W = 32;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_HOME      = 4'd1,
      S_MOVE_PICK = 4'd2,
      S_GRIP      = 4'd3,
      S_LIFT      = 4'd4,
      S_MOVE_DROP = 4'd5,
      S_RELEASE   = 4'd6,
      S_RETURN    = 4'd7,
      S_DONE      = 4'd8
   } state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   timer_q, timer_d;
   logic [W-1:0]   pick_x_q, pick_x_d;
   logic [W-1:0]   pick_y_q, pick_y_d;
   logic [W-1:0]   drop_x_q, drop_x_d;
   logic [W-1:0]   drop_y_q, drop_y_d;
   logic           aborted_q, aborted_d;
   logic [W-1:0]   x_q, x_d;
   logic [W-1:0]   y_q, y_d;
   logic           en1_q, en1_d;
   logic           en2_q, en2_d;
   logic           catch_q, catch_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
   logic [W-1:0]   xita1_q, xita2_q;
   logic           expired;
   logic           abortable;

   assign expired   = (timer_q == '0);
   assign abortable = (state_q == S_HOME)      || (state_q == S_MOVE_PICK) ||
                      (state_q == S_GRIP)      || (state_q == S_LIFT)      ||
                      (state_q == S_MOVE_DROP) || (state_q == S_RELEASE);

   // Next state, latches and sticky error
   always_comb begin
      state_d   = state_q;
      pick_x_d  = pick_x_q;
      pick_y_d  = pick_y_q;
      drop_x_d  = drop_x_q;
      drop_y_d  = drop_y_q;
      aborted_d = aborted_q;
      err_d     = err_q;

      unique case (state_q)
         S_IDLE: begin
            // abort in IDLE blocks acceptance and leaves err untouched
            if (!abort && start) begin
               if (pick_y[W-1] || drop_y[W-1]) begin
                  err_d = 1'b1;
               end else begin
                  state_d   = S_HOME;
                  pick_x_d  = pick_x;
                  pick_y_d  = pick_y;
                  drop_x_d  = drop_x;
                  drop_y_d  = drop_y;
                  aborted_d = 1'b0;
                  err_d     = 1'b0;
               end
            end
         end
         S_HOME:      if (expired) state_d = S_MOVE_PICK;
         S_MOVE_PICK: if (expired) state_d = S_GRIP;
         S_GRIP:      if (expired) state_d = S_LIFT;
         S_LIFT:      if (expired) state_d = S_MOVE_DROP;
         S_MOVE_DROP: if (expired) state_d = S_RELEASE;
         S_RELEASE:   if (expired) state_d = S_RETURN;
         S_RETURN: begin
            // an aborted run returns straight to IDLE without done
            if (expired) state_d = aborted_q ? S_IDLE : S_DONE;
         end
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase

      // abort overrides any timed transition, including an expiring one
      if (abort && abortable) begin
         state_d   = S_RETURN;
         aborted_d = 1'b1;
         err_d     = 1'b1;
      end
   end

   // Timer: reload T-1 on every state change, else count down to zero
   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q) begin
         unique case (state_d)
            S_GRIP, S_RELEASE: timer_d = T_GRIP - 32'd1;
            S_HOME, S_MOVE_PICK, S_LIFT, S_MOVE_DROP, S_RETURN:
                               timer_d = T_MOVE - 32'd1;
            default:           timer_d = '0;
         endcase
      end else if (!expired) begin
         timer_d = timer_q - 32'd1;
      end
   end

   // Registered outputs decoded from the next state
   always_comb begin
      en1_d   = 1'b0;
      en2_d   = 1'b0;
      catch_d = 1'b0;
      done_d  = 1'b0;
      busy_d  = (state_d != S_IDLE);
      x_d     = x_q;
      y_d     = y_q;
      unique case (state_d)
         S_IDLE: ;
         S_HOME:      en2_d = 1'b1;
         S_MOVE_PICK: begin
            en1_d = 1'b1;
            x_d   = pick_x_q;
            y_d   = pick_y_q;
         end
         S_GRIP: begin
            en1_d   = 1'b1;
            catch_d = 1'b1;
            x_d     = pick_x_q;
            y_d     = pick_y_q;
         end
         S_LIFT: begin
            en2_d   = 1'b1;
            catch_d = 1'b1;
         end
         S_MOVE_DROP: begin
            en1_d   = 1'b1;
            catch_d = 1'b1;
            x_d     = drop_x_q;
            y_d     = drop_y_q;
         end
         S_RELEASE: begin
            en1_d = 1'b1;
            x_d   = drop_x_q;
            y_d   = drop_y_q;
         end
         S_RETURN:    en2_d  = 1'b1;
         S_DONE:      done_d = 1'b1;
         default: ;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         pick_x_q  <= '0;
         pick_y_q  <= '0;
         drop_x_q  <= '0;
         drop_y_q  <= '0;
         aborted_q <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         en1_q     <= 1'b0;
         en2_q     <= 1'b0;
         catch_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         xita1_q   <= HOME_XITA1;
         xita2_q   <= HOME_XITA2;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         pick_x_q  <= pick_x_d;
         pick_y_q  <= pick_y_d;
         drop_x_q  <= drop_x_d;
         drop_y_q  <= drop_y_d;
         aborted_q <= aborted_d;
         x_q       <= x_d;
         y_q       <= y_d;
         en1_q     <= en1_d;
         en2_q     <= en2_d;
         catch_q   <= catch_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         xita1_q   <= HOME_XITA1;
         xita2_q   <= HOME_XITA2;
      end
   end

   assign x         = x_q;
   assign y         = y_q;
   assign en1       = en1_q;
   assign en2       = en2_q;
   assign catch     = catch_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign set_xita1 = xita1_q;
   assign set_xita2 = xita2_q;

endmodule

// File: tb/tb_arm_pick_place_seq.sv
// Testbench for arm_pick_place_seq with short T_MOVE/T_GRIP.
// Expected behaviour comes from a phase-timeline model: phase lengths and
// per-phase outputs are derived from the sequence description.
module tb_arm_pick_place_seq;

   localparam logic [31:0] TM  = 32'd10;
   localparam logic [31:0] TG  = 32'd4;
   localparam logic [31:0] HX1 = 32'h005A_0000;
   localparam logic [31:0] HX2 = 32'h005A_0000;
   localparam int          SEQ_LEN = 5 * 10 + 2 * 4;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [31:0] pick_x, pick_y, drop_x, drop_y;
   logic [31:0] x, y, set_xita1, set_xita2;
   logic        en1, en2, catch, busy, done, err;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   // model of held x/y and sticky err
   logic [31:0] mdl_x, mdl_y;
   logic        mdl_err;

   always #5 clk = ~clk;

   arm_pick_place_seq #(
      .T_MOVE(TM), .T_GRIP(TG), .HOME_XITA1(HX1), .HOME_XITA2(HX2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .pick_x(pick_x), .pick_y(pick_y), .drop_x(drop_x), .drop_y(drop_y),
      .x(x), .y(y), .en1(en1), .en2(en2),
      .set_xita1(set_xita1), .set_xita2(set_xita2),
      .catch(catch), .busy(busy), .done(done), .err(err)
   );

   // Phases: 0 IDLE, 1 HOME, 2 MOVE_PICK, 3 GRIP, 4 LIFT, 5 MOVE_DROP,
   // 6 RELEASE, 7 RETURN, 8 DONE. k = cycles since the accepting edge.
   function automatic int nominal_phase(int k);
      int acc = 0;
      int d;
      for (int p = 1; p <= 7; p++) begin
         d = (p == 3 || p == 6) ? int'(TG) : int'(TM);
         if (k < acc + d) return p;
         acc += d;
      end
      if (k == acc) return 8;
      return 0;
   endfunction

   function automatic bit abort_hits(int ka);
      int pa;
      if (ka < 0) return 1'b0;
      pa = nominal_phase(ka);
      return (pa >= 1 && pa <= 6);
   endfunction

   function automatic int model_phase(int k, int ka);
      if (abort_hits(ka) && k > ka) return (k - ka - 1 < int'(TM)) ? 7 : 0;
      return nominal_phase(k);
   endfunction

   // {en1, en2, catch} per phase
   function automatic logic [2:0] ctl(int p);
      case (p)
         1:       return 3'b010;
         2:       return 3'b100;
         3:       return 3'b101;
         4:       return 3'b011;
         5:       return 3'b101;
         6:       return 3'b100;
         7:       return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         checks++;
         if ((en1 && en2) || set_xita1 !== HX1 || set_xita2 !== HX2) begin
            errors++;
            $display("FAIL monitor en1=%b en2=%b xita1=%h xita2=%h (need en1&en2=0, xita=%h/%h)",
                     en1, en2, set_xita1, set_xita2, HX1, HX2);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full request. ka: abort cycle, ks: busy start-pulse cycle,
   // kc: cycle at which the coordinate inputs are scrambled (-1 = none).
   task automatic run_seq(input logic [31:0] px, input logic [31:0] py,
                          input logic [31:0] dx, input logic [31:0] dy,
                          input int ka, input int ks, input int kc,
                          input string name);
      int p;
      logic [2:0] c;
      logic exp_err;
      start = 1'b1; abort = 1'b0;
      pick_x = px; pick_y = py; drop_x = dx; drop_y = dy;
      tick();
      start = 1'b0;
      for (int k = 0; k <= SEQ_LEN + 2; k++) begin
         p = model_phase(k, ka);
         c = ctl(p);
         if (p == 2 || p == 3) begin mdl_x = px; mdl_y = py; end
         else if (p == 5 || p == 6) begin mdl_x = dx; mdl_y = dy; end
         exp_err = abort_hits(ka) && (k > ka);
         checks++;
         if ({en1, en2, catch, busy, done, err} !== {c, p != 0, p == 8, exp_err}) begin
            errors++;
            $display("FAIL %s k=%0d ctl {en1,en2,catch,busy,done,err} got %b%b%b%b%b%b need %b%b%b%b",
                     name, k, en1, en2, catch, busy, done, err, c, p != 0, p == 8, exp_err);
         end
         if (p == 0 || p == 2 || p == 3 || p == 5 || p == 6) begin
            checks++;
            if (x !== mdl_x || y !== mdl_y) begin
               errors++;
               $display("FAIL %s k=%0d xy got %h/%h need %h/%h", name, k, x, y, mdl_x, mdl_y);
            end
         end
         abort = (k == ka);
         if (k == ks) begin
            start  = 1'b1;
            pick_x = $urandom;
            pick_y = $urandom & 32'h7FFF_FFFF;
         end else begin
            start = 1'b0;
         end
         if (k == kc) begin
            pick_x = ~px; pick_y = py ^ 32'h0001_0000; drop_x = ~dx; drop_y = dy ^ 32'h0002_0000;
         end
         tick();
         mdl_err = exp_err;
      end
      abort = 1'b0; start = 1'b0;
      mdl_err = abort_hits(ka);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      pick_x = '0; pick_y = '0; drop_x = '0; drop_y = '0;
      tick(); tick();
      checks++;
      if ({x, y, en1, en2, catch, busy, done, err} !== '0 ||
          set_xita1 !== HX1 || set_xita2 !== HX2) begin
         errors++;
         $display("FAIL reset x=%h y=%h ctl=%b%b%b%b%b%b xita=%h/%h need zeros and home angles",
                  x, y, en1, en2, catch, busy, done, err, set_xita1, set_xita2);
      end
      rst = 1'b0;
      mdl_x = '0; mdl_y = '0; mdl_err = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || en2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle busy=%b en2=%b need 0/0", busy, en2);
      end
   endtask

   task automatic test_reject();
      start = 1'b1;
      pick_x = 32'h000A_0000; pick_y = 32'hFFFF_0000;
      drop_x = 32'hFFF6_0000; drop_y = 32'h0008_0000;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || err !== 1'b1 || en2 !== 1'b0) begin
         errors++;
         $display("FAIL reject busy=%b err=%b en2=%b need 0/1/0", busy, err, en2);
      end
      mdl_err = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || err !== 1'b1 || x !== mdl_x) begin
         errors++;
         $display("FAIL reject_hold busy=%b err=%b x=%h need 0/1/%h", busy, err, x, mdl_x);
      end
   endtask

   task automatic test_idle_abort();
      start = 1'b1; abort = 1'b1;
      pick_x = 32'h0001_0000; pick_y = 32'h0001_0000;
      drop_x = 32'h0002_0000; drop_y = 32'h0002_0000;
      tick();
      start = 1'b0;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || err !== mdl_err || en2 !== 1'b0) begin
         errors++;
         $display("FAIL idle_abort busy=%b err=%b en2=%b need 0/%b/0", busy, err, en2, mdl_err);
      end
   endtask

   task automatic test_random();
      logic [31:0] px, py, dx, dy;
      int ka;
      for (int r = 0; r < 8; r++) begin
         px = $urandom; dx = $urandom;
         py = $urandom & 32'h7FFF_FFFF;
         dy = $urandom & 32'h7FFF_FFFF;
         ka = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, SEQ_LEN));
         run_seq(px, py, dx, dy, ka, -1, int'($urandom_range(0, 40)), "random");
      end
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      pick_x = 32'h0003_0000; pick_y = 32'h0004_0000;
      drop_x = 32'h0005_0000; drop_y = 32'h0006_0000;
      tick();
      start = 1'b0;
      for (int k = 0; k < 38; k++) tick();
      checks++;
      if (en1 !== 1'b1 || catch !== 1'b1 || x !== 32'h0005_0000) begin
         errors++;
         $display("FAIL pre_reset en1=%b catch=%b x=%h need 1/1/00050000", en1, catch, x);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({x, y, en1, en2, catch, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL async_reset x=%h y=%h ctl=%b%b%b%b%b%b need zeros",
                  x, y, en1, en2, catch, busy, done, err);
      end
      tick(); tick();
      rst = 1'b0;
      mdl_x = '0; mdl_y = '0; mdl_err = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || en1 !== 1'b0 || en2 !== 1'b0 || x !== '0) begin
            errors++;
            $display("FAIL post_reset k=%0d busy=%b en1=%b en2=%b x=%h need idle zeros",
                     k, busy, en1, en2, x);
         end
      end
   endtask

   initial begin
      test_reset();
      mon_en = 1'b1;
      test_reject();
      run_seq(32'h000A_0000, 32'h0008_0000, 32'hFFF6_0000, 32'h0008_0000,
              -1, 29, 22, "normal");
      run_seq(32'h000A_0000, 32'h0008_0000, 32'hFFF6_0000, 32'h0008_0000,
              21, -1, -1, "abort_grip");
      test_idle_abort();
      test_random();
      test_reset_mid();
      run_seq(32'h0007_8000, 32'h0002_0000, 32'h0001_0000, 32'h0000_8000,
              -1, 12, 5, "after_reset");
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
